// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic MAC array.
// Imported by the PE and the top level.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FLUSH,
    DRAIN
  } state_t;

  function automatic int flush_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: registered a/b/tag forwarding and a
// tagged signed/unsigned multiply-accumulate with sync clear.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  tag_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  tag_out,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int XW = ACC_WIDTH - DATA_WIDTH;

  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] prod;
  logic                 a_msb;
  logic                 b_msb;

  // Low ACC_WIDTH bits of the product are correct for both modes
  always_comb begin
    a_msb = signed_mode & a_in[DATA_WIDTH-1];
    b_msb = signed_mode & b_in[DATA_WIDTH-1];
    a_ext = {{XW{a_msb}}, a_in};
    b_ext = {{XW{b_msb}}, b_in};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out   <= '0;
      b_out   <= '0;
      tag_out <= 1'b0;
      acc     <= '0;
    end else begin
      a_out   <= a_in;
      b_out   <= b_in;
      tag_out <= tag_in;
      if (clr) begin
        acc <= '0;
      end else if (tag_in) begin
        acc <= acc + prod;
      end
    end
  end

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary systolic matrix multiply: C = A x B, runtime K,
// skewed operand injection, flush, then backpressured row drain.
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 256,
  parameter int KW         = $clog2(K_MAX + 1),
  localparam int RW        = clog2_min1(ROWS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      signed_mode,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_vec,
  input  logic [COLS*DATA_WIDTH-1:0] b_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RW-1:0]             out_row,
  output logic [COLS*ACC_WIDTH-1:0] out_data,
  output logic                      out_last
);

  localparam int DW      = DATA_WIDTH;
  localparam int FLUSH_N = flush_cycles(ROWS, COLS);
  localparam int FW      = clog2_min1(FLUSH_N);

  state_t          state_q;
  state_t          state_d;
  logic [KW-1:0]   k_len_q;
  logic [KW-1:0]   beat_q;
  logic            signed_q;
  logic [FW-1:0]   flush_q;
  logic [RW-1:0]   row_q;
  logic            done_q;

  logic            start_ok;
  logic            beat_ok;
  logic            out_ok;
  logic            last_beat;
  logic            flush_end;
  logic            row_last;

  assign start_ok  = (state_q == IDLE) && start;
  assign in_ready  = (state_q == COMPUTE);
  assign beat_ok   = in_valid && in_ready;
  assign last_beat = (beat_q == k_len_q - KW'(1));
  assign flush_end = (flush_q == FW'(FLUSH_N - 1));
  assign out_valid = (state_q == DRAIN);
  assign row_last  = (row_q == RW'(ROWS - 1));
  assign out_last  = out_valid && row_last;
  assign out_ok    = out_valid && out_ready;
  assign out_row   = row_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (k_len == '0) ? DRAIN : COMPUTE;
        end
      end
      COMPUTE: begin
        if (beat_ok && last_beat) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_end) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ok && row_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_len_q  <= '0;
      signed_q <= 1'b0;
      beat_q   <= '0;
      flush_q  <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= out_ok && row_last;
      if (start_ok) begin
        k_len_q  <= k_len;
        signed_q <= signed_mode;
        beat_q   <= '0;
      end else if (beat_ok) begin
        beat_q <= beat_q + KW'(1);
      end
      if (state_q == FLUSH) begin
        flush_q <= flush_q + FW'(1);
      end else begin
        flush_q <= '0;
      end
      if (out_ok) begin
        row_q <= row_last ? '0 : row_q + RW'(1);
      end
    end
  end

  // Idle cycles push zeros with tag=0 so the grid keeps moving
  logic                 inj_tag;
  logic [ROWS*DW-1:0]   inj_a;
  logic [COLS*DW-1:0]   inj_b;

  assign inj_tag = beat_ok;
  assign inj_a   = beat_ok ? a_vec : '0;
  assign inj_b   = beat_ok ? b_vec : '0;

  logic [DW:0]          a_skew [ROWS];
  logic [DW-1:0]        b_skew [COLS];

  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    logic [DW:0] a_head;
    assign a_head = {inj_tag, inj_a[i*DW +: DW]};
    if (i == 0) begin : g_d0
      assign a_skew[i] = a_head;
    end else begin : g_dn
      logic [DW:0] sr [i];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < i; k++) sr[k] <= '0;
        end else begin
          sr[0] <= a_head;
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      end
      assign a_skew[i] = sr[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    logic [DW-1:0] b_head;
    assign b_head = inj_b[j*DW +: DW];
    if (j == 0) begin : g_d0
      assign b_skew[j] = b_head;
    end else begin : g_dn
      logic [DW-1:0] sr [j];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else begin
          sr[0] <= b_head;
          for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
        end
      end
      assign b_skew[j] = sr[j-1];
    end
  end

  logic [DW-1:0]        a_h   [ROWS][COLS+1];
  logic                 tag_h [ROWS][COLS+1];
  logic [DW-1:0]        b_v   [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0] acc   [ROWS][COLS];

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    assign a_h[i][0]   = a_skew[i][DW-1:0];
    assign tag_h[i][0] = a_skew[i][DW];
    logic unused_edge;
    assign unused_edge = ^{a_h[i][COLS], tag_h[i][COLS]};
    for (genvar j = 0; j < COLS; j++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_ok),
        .signed_mode (signed_q),
        .a_in        (a_h[i][j]),
        .b_in        (b_v[i][j]),
        .tag_in      (tag_h[i][j]),
        .a_out       (a_h[i][j+1]),
        .b_out       (b_v[i+1][j]),
        .tag_out     (tag_h[i][j+1]),
        .acc         (acc[i][j])
      );
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_btop
    assign b_v[0][j] = b_skew[j];
    logic unused_bot;
    assign unused_bot = ^b_v[ROWS][j];
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int j = 0; j < COLS; j++) begin
        out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed self-checking bench for systolic_mac_array (4x4, 8b/32b).
// Table of uniform jobs plus hand-written multi-cycle sequences.
module tb_systolic_mac_array;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int ACC  = 32;
  localparam int KW   = 9;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 signed_mode;
  logic                 busy;
  logic                 done;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   a_vec;
  logic [COLS*DW-1:0]   b_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_row;
  logic [COLS*ACC-1:0]  out_data;
  logic                 out_last;

  systolic_mac_array dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k_len       (k_len),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_vec       (a_vec),
    .b_vec       (b_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [ROWS*DW-1:0]  av [16];
  logic [COLS*DW-1:0]  bv [16];
  logic [COLS*ACC-1:0] exp_row [ROWS];

  typedef struct {
    int         k;
    bit         sgn;
    logic [7:0] a;
    logic [7:0] b;
    logic [31:0] c;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_uniform(input int k, input logic [7:0] a,
                              input logic [7:0] b, input logic [31:0] c);
    for (int n = 0; n < 16; n++) begin
      av[n] = {ROWS{a}};
      bv[n] = {COLS{b}};
    end
    for (int i = 0; i < ROWS; i++) exp_row[i] = {COLS{c}};
  endtask

  task automatic start_job(input int k, input bit sgn);
    start       = 1'b1;
    k_len       = KW'(k);
    signed_mode = sgn;
    @(negedge clk);
    start       = 1'b0;
    signed_mode = ~sgn;
  endtask

  task automatic feed(input int n, input bit gap);
    int  sent = 0;
    int  cyc  = 0;
    bit  tog  = 1'b0;
    bit  bub;
    while (sent < n && cyc < 200) begin
      bub      = gap && tog;
      in_valid = !bub;
      if (bub) begin
        a_vec = '1;
        b_vec = '1;
      end else begin
        a_vec = av[sent];
        b_vec = bv[sent];
      end
      if (in_valid && in_ready) sent++;
      tog = !tog;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    check("feed_beats", sent, n);
  endtask

  task automatic collect(input int stall_row, input int stall_n);
    int r     = 0;
    int cyc   = 0;
    int stall = 0;
    while (r < ROWS && cyc < 300) begin
      if (out_valid) begin
        check("row_idx", out_row, r);
        check("row_data", out_data, exp_row[r]);
        if (r == stall_row && stall < stall_n) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          check("row_last", out_last, (r == ROWS - 1));
          r++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_rows", r, ROWS);
    check("done_pulse", done, 1);
    @(negedge clk);
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic run_uniform(input int k, input bit sgn, input logic [7:0] a,
                             input logic [7:0] b, input logic [31:0] c);
    fill_uniform(k, a, b, c);
    start_job(k, sgn);
    check("busy_start", busy, 1);
    feed(k, 1'b0);
    collect(-1, 0);
  endtask

  initial begin
    int lat;

    tbl[0] = '{k: 1, sgn: 1'b1, a: 8'hFF, b: 8'h02, c: 32'hFFFF_FFFE};
    tbl[1] = '{k: 1, sgn: 1'b0, a: 8'hFF, b: 8'h02, c: 32'h0000_01FE};
    tbl[2] = '{k: 5, sgn: 1'b1, a: 8'hFD, b: 8'h07, c: 32'hFFFF_FF97};
    tbl[3] = '{k: 6, sgn: 1'b0, a: 8'h10, b: 8'h10, c: 32'h0000_0600};
    tbl[4] = '{k: 2, sgn: 1'b0, a: 8'hFF, b: 8'hFF, c: 32'h0001_FC02};

    rst         = 1'b1;
    start       = 1'b0;
    k_len       = '0;
    signed_mode = 1'b0;
    in_valid    = 1'b0;
    a_vec       = '0;
    b_vec       = '0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      run_uniform(tbl[t].k, tbl[t].sgn, tbl[t].a, tbl[t].b, tbl[t].c);
    end

    // identity: A = I, B[k][j] = 4k+j+1, plus first-valid latency
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < ROWS; i++) av[k][i*DW +: DW] = (i == k) ? 8'd1 : 8'd0;
      for (int j = 0; j < COLS; j++) bv[k][j*DW +: DW] = 8'(4 * k + j + 1);
    end
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) exp_row[i][j*ACC +: ACC] = 32'(4 * i + j + 1);
    start_job(4, 1'b0);
    feed(4, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("first_valid_lat", lat, 7);
    collect(-1, 0);

    // bubbles: valid alternating, extra beat after the third is dropped
    fill_uniform(3, 8'd1, 8'd1, 32'd3);
    start_job(3, 1'b0);
    feed(3, 1'b1);
    check("in_ready_drop", in_ready, 0);
    in_valid = 1'b1;
    a_vec    = {ROWS{8'h05}};
    b_vec    = {COLS{8'h05}};
    @(negedge clk);
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    collect(-1, 0);

    // backpressure on row 1: A[i][k]=i+1, B[k][j]=j+1, K=2
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < ROWS; i++) av[k][i*DW +: DW] = 8'(i + 1);
      for (int j = 0; j < COLS; j++) bv[k][j*DW +: DW] = 8'(j + 1);
    end
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) exp_row[i][j*ACC +: ACC] = 32'(2 * (i + 1) * (j + 1));
    start_job(2, 1'b0);
    feed(2, 1'b0);
    collect(1, 5);

    // reset mid-COMPUTE after two beats, then a clean K=1 job
    fill_uniform(4, 8'd9, 8'd9, 32'd0);
    start_job(4, 1'b0);
    feed(2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_no_done", done, 0);
    run_uniform(1, 1'b0, 8'd1, 8'd1, 32'd1);

    // K=0 with a second start during DRAIN
    fill_uniform(0, 8'd0, 8'd0, 32'd0);
    start_job(0, 1'b0);
    check("k0_drain", out_valid, 1);
    start = 1'b1;
    k_len = KW'(2);
    @(negedge clk);
    start = 1'b0;
    collect(-1, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("k0_stay_idle", busy, 0);
      check("k0_one_done", done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_mac_array.md
Name: systolic_mac_array

Overview:
Output-stationary systolic matrix-multiply engine. Computes C[ROWS x COLS] = A[ROWS x K] x B[K x COLS] with runtime K.
Operands stream in one k-slice per beat over a valid/ready handshake. Internal skew registers move A rightward and B downward through a PE grid. After the last beat the array flushes, then drains results one row per beat over a second valid/ready handshake.
Successor to the broadcast MAC grid. Adds systolic dataflow, runtime K, signed/unsigned mode, bubble tolerance, backpressured result drain and a job-control FSM.

Parameters:
ROWS, 4, PE grid rows (rows of A / C), >=1
COLS, 4, PE grid columns (columns of B / C), >=1
DATA_WIDTH, 8, operand element width
ACC_WIDTH, 32, accumulator / result element width, >= 2*DATA_WIDTH
K_MAX, 256, maximum k_len
KW, $clog2(K_MAX+1), width of k_len

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job start pulse; sampled only in IDLE
k_len  in  KW  inner dimension K; captured on accepted start
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured on accepted start
busy  out  1  high from accepted start through final drain beat
done  out  1  one-cycle pulse the cycle after final drain handshake
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid && in_ready
a_vec  in  ROWS*DATA_WIDTH  A[i][k] at bits [(i+1)*DW-1 : i*DW]
b_vec  in  COLS*DATA_WIDTH  B[k][j] at bits [(j+1)*DW-1 : j*DW]
out_valid  out  1  result row valid
out_ready  in  1  result row consumed when out_valid && out_ready
out_row  out  $clog2(ROWS) (min 1)  index i of row presented
out_data  out  COLS*ACC_WIDTH  C[i][j] at bits [(j+1)*ACC-1 : j*ACC]
out_last  out  1  high with out_valid on row ROWS-1

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; accumulators, skew registers and beat counter cleared.
  - busy, done, in_ready, out_valid, out_last = 0; out_row = 0; out_data = 0.
- IDLE:
  - start=1: capture k_len and signed_mode, clear all accumulators, busy=1.
  - Next state COMPUTE, or DRAIN if k_len==0.
- COMPUTE:
  - in_ready=1. Each accepted beat injects a_vec/b_vec into the skew inputs with a valid tag.
  - Cycles without an accepted beat inject zeros with tag=0.
  - The pipeline advances every cycle regardless of in_valid.
  - After the k_len-th accepted beat, in_ready drops the next cycle and state goes to FLUSH.
- Skew:
  - Row i's A element is delayed i cycles; column j's B element is delayed j cycles.
  - PE(i,j) forwards A to (i,j+1) and B to (i+1,j), registered, one cycle per hop.
  - PE accumulates only when its tag is 1: acc += ext(a)*ext(b). Extension is sign or zero per captured signed_mode, to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation.
- FLUSH:
  - Lasts exactly ROWS+COLS-1 cycles, so the last beat reaches PE(ROWS-1,COLS-1) and accumulates. Then DRAIN.
- DRAIN:
  - out_valid=1, out_row=r, out_data = accumulators of row r, starting at r=0. out_last = (r==ROWS-1).
  - On handshake r increments. Outputs are held stable while out_ready=0.
  - After the out_last handshake: IDLE, busy=0, done=1 for one cycle.
- Latency:
  - First out_valid is ROWS+COLS cycles after the cycle accepting the last beat.
  - Minimum job time is k_len + ROWS+COLS-1 + ROWS cycles, plus 1 for the start cycle.
- Boundary rules:
  - start outside IDLE is ignored; captured parameters are unchanged.
  - k_len==0: skip COMPUTE and FLUSH; drain ROWS rows of zeros.
  - k_len > K_MAX is out of contract (not checked).
  - in_valid while in_ready=0 is ignored; data is not buffered.
  - Reset mid-job aborts immediately: no done pulse, partial sums discarded.
  - done and start in the same cycle: start is accepted (state is already IDLE).

Decomposition:
- Package systolic_pkg:
  - state enum (IDLE, COMPUTE, FLUSH, DRAIN)
  - FLUSH_CYCLES = ROWS+COLS-1 expressed as a function
  - helper function for the clog2-with-min-1 width
- Sub-module systolic_pe:
  - registered a/b/tag forwarding
  - tagged signed/unsigned multiply-accumulate
  - synchronous clear
- Top level: skew delay lines, FSM, beat/flush/drain counters, output row mux.

Test Plan:
- Identity, ROWS=COLS=4, k_len=4, unsigned: A=I, B[k][j]=4k+j+1. Expect out rows 0..3 = B rows ({1,2,3,4}...{13,14,15,16}), out_last only on row 3, then a done pulse.
- Sign mode, k_len=1, all a=0xFF, all b=0x02. signed_mode=1: every C = 0xFFFFFFFE. signed_mode=0: every C = 0x000001FE.
- Bubbles, k_len=3, all operands 1, in_valid alternating 1,0. Every C=3; in_ready falls the cycle after the 3rd accepted beat; the extra valid beat is ignored.
- Backpressure: out_ready low for 5 cycles while row 1 is presented. out_row=1 and out_data stay stable; all 4 rows arrive exactly once, in order.
- Reset mid-COMPUTE after 2 beats: next cycle busy=0, in_ready=0, no done. A following k_len=1 job with a=b=1 yields every C=1 (no stale sums).
- k_len=0 start, with a second start pulse asserted during DRAIN. Expect 4 zero rows, one done, and the second start ignored (busy returns to 0).
